// File: rtl/cg_ctrl_pkg.sv
// Shared definitions for the clock-gate controller: FSM state
// encoding and a helper that sizes the internal cycle counters.
package cg_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WAKE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HOLD   = 2'd3
    } gate_state_e;

    // Bits needed to hold values 0..max_val inclusive (at least 1).
    function automatic int cnt_width(input int max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cg_timer.sv
// Generic up-counter with clear, enable and a terminal-count flag that
// is high while the count equals TC-1. Clear has priority over enable.
module cg_timer
    import cg_ctrl_pkg::*;
#(
    parameter int TC = 2,
    parameter int W  = cnt_width(TC)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count: clear wins, otherwise advance when enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == W'(TC - 1));

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable sequencer: OFF -> WAKE -> ACTIVE <-> HOLD -> OFF.
// Optional gated-cycle statistics counter when CG_STATS_EN is defined.
module clk_gate_ctrl
    import cg_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int WAKE_CYCLES  = 2,
    parameter int IDLE_TIMEOUT = 8
`ifdef CG_STATS_EN
  , parameter int CNT_W        = 16
`endif
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic               FORCE_ON,
    output logic               CLK_EN,
    output logic               READY,
    output logic [1:0]         GATE_STATE
`ifdef CG_STATS_EN
  , output logic [CNT_W-1:0]   GATED_CNT
  , input  logic               CNT_CLR
`endif
);

    gate_state_e state_d;
    gate_state_e state_q;
    logic        clk_en_d;
    logic        clk_en_q;
    logic        ready_d;
    logic        ready_q;

    logic any_req;
    logic wake_clr;
    logic wake_en;
    logic wake_tc;
    logic idle_clr;
    logic idle_en;
    logic idle_tc;

    assign any_req = (|REQ) | FORCE_ON;

    // Wake timer runs only in WAKE; it sits at zero everywhere else.
    assign wake_en  = (state_q == ST_WAKE);
    assign wake_clr = ~wake_en;

    // Idle timer counts consecutive idle HOLD cycles; any request restarts it.
    assign idle_en  = (state_q == ST_HOLD) & ~any_req;
    assign idle_clr = (state_q != ST_HOLD) | any_req;

    cg_timer #(
        .TC  (WAKE_CYCLES)
    ) u_wake_timer (
        .clk (CLK),
        .rst (RST),
        .clr (wake_clr),
        .en  (wake_en),
        .tc  (wake_tc)
    );

    cg_timer #(
        .TC  (IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk (CLK),
        .rst (RST),
        .clr (idle_clr),
        .en  (idle_en),
        .tc  (idle_tc)
    );

    // Next state and the registered enable/ready it implies.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF: begin
                if (any_req) begin
                    state_d = ST_WAKE;
                end
            end
            ST_WAKE: begin
                if (wake_tc) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!any_req) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (any_req) begin
                    state_d = ST_ACTIVE;
                end else if (idle_tc) begin
                    state_d = ST_OFF;
                end
            end
            default: state_d = ST_OFF;
        endcase
        clk_en_d = (state_d != ST_OFF);
        ready_d  = (state_d == ST_ACTIVE) | (state_d == ST_HOLD);
    end

    // FSM and output registers; reset forces the gate closed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_OFF;
            clk_en_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            clk_en_q <= clk_en_d;
            ready_q  <= ready_d;
        end
    end

    assign CLK_EN     = clk_en_q;
    assign READY      = ready_q;
    assign GATE_STATE = state_q;

`ifdef CG_STATS_EN
    logic [CNT_W-1:0] gated_cnt_d;
    logic [CNT_W-1:0] gated_cnt_q;

    // Saturating count of cycles with the gate closed; clear wins.
    always_comb begin
        gated_cnt_d = gated_cnt_q;
        if (CNT_CLR) begin
            gated_cnt_d = '0;
        end else if (!clk_en_q && (gated_cnt_q != '1)) begin
            gated_cnt_d = gated_cnt_q + CNT_W'(1);
        end
    end

    // Statistics register with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            gated_cnt_q <= '0;
        end else begin
            gated_cnt_q <= gated_cnt_d;
        end
    end

    assign GATED_CNT = gated_cnt_q;
`else
    // No statistics counter in this build.
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios plus
// randomized traffic against a timeline-based reference model.
module tb_clk_gate_ctrl;

    localparam int NR = 2;
    localparam int WC = 2;
    localparam int IT = 8;
`ifdef CG_STATS_EN
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
`else
    localparam int CMAX = 0;
`endif

    logic          CLK      = 1'b0;
    logic          RST      = 1'b1;
    logic [NR-1:0] REQ      = '0;
    logic          FORCE_ON = 1'b0;
    logic          CNT_CLR  = 1'b0;
    logic          CLK_EN;
    logic          READY;
    logic [1:0]    GATE_STATE;
`ifdef CG_STATS_EN
    logic [CW-1:0] GATED_CNT;
`endif

    int errors = 0;
    int checks = 0;

    clk_gate_ctrl #(
        .NUM_REQ      (NR),
        .WAKE_CYCLES  (WC),
        .IDLE_TIMEOUT (IT)
`ifdef CG_STATS_EN
      , .CNT_W        (CW)
`endif
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ        (REQ),
        .FORCE_ON   (FORCE_ON),
        .CLK_EN     (CLK_EN),
        .READY      (READY),
        .GATE_STATE (GATE_STATE)
`ifdef CG_STATS_EN
      , .GATED_CNT  (GATED_CNT)
      , .CNT_CLR    (CNT_CLR)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference model: gate is "on" from the request edge; ready after
    // WC further edges; closes on the (IT+1)-th consecutive idle edge
    // seen while ready (the first idle edge is the move into HOLD).
    typedef struct packed {
        logic       on;
        logic       rdy;
        logic [1:0] st;
        int         wage;
        int         idle;
        int         g;
    } model_t;

    model_t m = '0;

    function automatic model_t model_next(input model_t c, input logic r,
                                          input logic rst, input logic clr);
        model_t n = c;
        if (rst) begin
            n = '0;
            return n;
        end
        if (clr) n.g = 0;
        else if (!c.on && c.g < CMAX) n.g = c.g + 1;
        if (!c.on) begin
            if (r) begin
                n.on = 1'b1; n.st = 2'd1; n.wage = 0;
            end
        end else if (!c.rdy) begin
            n.wage = c.wage + 1;
            if (n.wage == WC) begin
                n.rdy = 1'b1; n.st = 2'd2; n.idle = 0;
            end
        end else if (r) begin
            n.idle = 0; n.st = 2'd2;
        end else begin
            n.idle = c.idle + 1;
            if (n.idle == 1) n.st = 2'd3;
            if (n.idle == IT + 1) begin
                n.on = 1'b0; n.rdy = 1'b0; n.st = 2'd0;
            end
        end
        return n;
    endfunction

    always @(posedge CLK) begin
        m <= model_next(m, (|REQ) | FORCE_ON, RST, CNT_CLR);
    end

    task automatic test_reset();
        RST = 1'b1;
        REQ = '0;
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            checks++;
            if (CLK_EN !== 1'b0 || READY !== 1'b0 || GATE_STATE !== 2'd0) begin
                errors++;
                $display("FAIL reset_idle k=%0d: en=%b rdy=%b st=%0d want 0 0 0",
                         k, CLK_EN, READY, GATE_STATE);
            end
        end
`ifdef CG_STATS_EN
        checks++;
        if (GATED_CNT !== CW'((20 > CMAX) ? CMAX : 20)) begin
            errors++;
            $display("FAIL reset_gated_cnt: got %0d want %0d", GATED_CNT,
                     (20 > CMAX) ? CMAX : 20);
        end
`endif
    endtask

    task automatic test_pulse();
        logic       en;
        logic       rdy;
        logic [1:0] st;
        int         off_k;
        off_k = 1 + WC + 1 + IT;
        REQ = 2'b01;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            REQ = '0;
            en  = (k < off_k);
            rdy = (k >= 1 + WC) && (k < off_k);
            if (k < 1 + WC)       st = 2'd1;
            else if (k == 1 + WC) st = 2'd2;
            else if (k < off_k)   st = 2'd3;
            else                  st = 2'd0;
            checks++;
            if (CLK_EN !== en || READY !== rdy || GATE_STATE !== st) begin
                errors++;
                $display("FAIL pulse k=%0d: en=%b rdy=%b st=%0d want %b %b %0d",
                         k, CLK_EN, READY, GATE_STATE, en, rdy, st);
            end
        end
    endtask

    task automatic test_expiry();
        logic       en;
        logic       rdy;
        logic [1:0] st;
        int         ex;
        int         off_k;
        ex    = WC + 2 + IT;
        off_k = ex + 1 + IT;
        REQ = 2'b10;
        for (int k = 1; k <= off_k + 3; k++) begin
            @(negedge CLK);
            REQ = (k == ex - 1) ? 2'b10 : 2'b00;
            en  = (k < off_k);
            rdy = (k > WC) && (k < off_k);
            if (k <= WC)          st = 2'd1;
            else if (k == WC + 1) st = 2'd2;
            else if (k < ex)      st = 2'd3;
            else if (k == ex)     st = 2'd2;
            else if (k < off_k)   st = 2'd3;
            else                  st = 2'd0;
            checks++;
            if (CLK_EN !== en || READY !== rdy || GATE_STATE !== st) begin
                errors++;
                $display("FAIL expiry k=%0d: en=%b rdy=%b st=%0d want %b %b %0d",
                         k, CLK_EN, READY, GATE_STATE, en, rdy, st);
            end
        end
    endtask

    task automatic test_force();
        logic [1:0] st;
        FORCE_ON = 1'b1;
        REQ = '0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge CLK);
            st = (k <= WC) ? 2'd1 : 2'd2;
            checks++;
            if (CLK_EN !== 1'b1 || READY !== (k > WC) || GATE_STATE !== st) begin
                errors++;
                $display("FAIL force k=%0d: en=%b rdy=%b st=%0d want 1 %b %0d",
                         k, CLK_EN, READY, GATE_STATE, k > WC, st);
            end
        end
        FORCE_ON = 1'b0;
        repeat (IT + 1) @(negedge CLK);
        checks++;
        if (CLK_EN !== 1'b0 || GATE_STATE !== 2'd0) begin
            errors++;
            $display("FAIL force_release: en=%b st=%0d want 0 0", CLK_EN, GATE_STATE);
        end
    endtask

    task automatic test_reset_wake();
        REQ = 2'b01;
        @(negedge CLK);
        checks++;
        if (GATE_STATE !== 2'd1 || CLK_EN !== 1'b1) begin
            errors++;
            $display("FAIL rw_enter: st=%0d en=%b want 1 1", GATE_STATE, CLK_EN);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        REQ = '0;
        checks++;
        if (CLK_EN !== 1'b0 || READY !== 1'b0 || GATE_STATE !== 2'd0) begin
            errors++;
            $display("FAIL rw_reset: en=%b rdy=%b st=%0d want 0 0 0",
                     CLK_EN, READY, GATE_STATE);
        end
        REQ = 2'b01;
        for (int k = 1; k <= WC + 1; k++) begin
            @(negedge CLK);
            REQ = '0;
            checks++;
            if (CLK_EN !== 1'b1 || READY !== (k > WC)) begin
                errors++;
                $display("FAIL rw_rewake k=%0d: en=%b rdy=%b want 1 %b",
                         k, CLK_EN, READY, k > WC);
            end
        end
        repeat (IT + 4) @(negedge CLK);
    endtask

`ifdef CG_STATS_EN
    task automatic test_stats();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        checks++;
        if (GATED_CNT !== CW'(CMAX)) begin
            errors++;
            $display("FAIL stats_sat: got %0d want %0d", GATED_CNT, CMAX);
        end
        CNT_CLR = 1'b1;
        @(negedge CLK);
        CNT_CLR = 1'b0;
        checks++;
        if (GATED_CNT !== '0) begin
            errors++;
            $display("FAIL stats_clr: got %0d want 0", GATED_CNT);
        end
        @(negedge CLK);
        checks++;
        if (GATED_CNT !== CW'(1)) begin
            errors++;
            $display("FAIL stats_after_clr: got %0d want 1", GATED_CNT);
        end
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            REQ = ($urandom_range(0, 11) == 0) ? NR'($urandom) : '0;
            if ($urandom_range(0, 59) == 0) FORCE_ON = ~FORCE_ON;
            RST = ($urandom_range(0, 149) == 0);
            CNT_CLR = ($urandom_range(0, 39) == 0);
            @(negedge CLK);
            checks++;
            if (CLK_EN !== m.on || READY !== m.rdy || GATE_STATE !== m.st) begin
                errors++;
                $display("FAIL random k=%0d: en=%b rdy=%b st=%0d want %b %b %0d",
                         k, CLK_EN, READY, GATE_STATE, m.on, m.rdy, m.st);
            end
`ifdef CG_STATS_EN
            checks++;
            if (GATED_CNT !== CW'(m.g)) begin
                errors++;
                $display("FAIL random_cnt k=%0d: got %0d want %0d", k, GATED_CNT, m.g);
            end
`endif
        end
        RST = 1'b0;
        FORCE_ON = 1'b0;
        CNT_CLR = 1'b0;
        REQ = '0;
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_expiry();
        test_force();
        test_reset_wake();
`ifdef CG_STATS_EN
        test_stats();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
